// File: rtl/winograd_pkg.sv
// Shared types and tile geometry for the Winograd result path.
// The tile index counter is sized from these so the upstream loader can reuse it.
package winograd_pkg;

  localparam int WG_TILE_ROWS = 8;
  localparam int WG_TILE_COLS = 10;
  localparam int WG_DATA_W    = 16;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } wg_stream_state_t;

  typedef logic [WG_DATA_W-1:0] wg_elem_t;

endpackage

// File: rtl/wg_tile_index_counter.sv
// Row-major (row, col) walker over a ROWS x COLS tile.
// Clear has priority over advance; advancing from the last element wraps to (0,0).
module wg_tile_index_counter #(
  parameter int ROWS = 8,
  parameter int COLS = 10,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_advance,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_last
);

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;

  // Index register: column steps every advance, row steps on column wrap.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_advance) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = (r_row == ROW_MAX) && (r_col == COL_MAX);

endmodule

// File: rtl/winograd_result_streamer.sv
// Captures the engine's parallel result tile on conv_done and replays it as a
// row-major valid/ready element stream; a done arriving mid-tile is dropped and flagged.
module winograd_result_streamer
  import winograd_pkg::*;
#(
  parameter int ROWS       = WG_TILE_ROWS,
  parameter int COLS       = WG_TILE_COLS,
  parameter int DATA_WIDTH = WG_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     conv_done,
  input  logic [DATA_WIDTH-1:0]    result_in [0:ROWS-1][0:COLS-1],
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic [$clog2(ROWS)-1:0]  m_row,
  output logic [$clog2(COLS)-1:0]  m_col,
  output logic                     m_last,
  output logic                     busy,
  output logic                     overrun,
  input  logic                     clr_overrun
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  wg_stream_state_t r_state;
  wg_stream_state_t w_state_nxt;

  logic [DATA_WIDTH-1:0] r_buf [0:ROWS-1][0:COLS-1];
  logic                  r_overrun;

  logic          w_capture;
  logic          w_clear;
  logic          w_advance;
  logic          w_drop;
  logic          w_hs;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic          w_last;

  assign w_hs = (r_state == STREAM) && m_ready;

  wg_tile_index_counter #(
    .ROWS (ROWS),
    .COLS (COLS),
    .RW   (RW),
    .CW   (CW)
  ) u_index (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_last    (w_last)
  );

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_clear     = 1'b0;
    w_advance   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      IDLE: begin
        if (conv_done) begin
          w_capture   = 1'b1;
          w_clear     = 1'b1;
          w_state_nxt = STREAM;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      STREAM: begin
        if (w_hs && w_last) begin
          // A done coinciding with the final beat chains the next tile with no bubble.
          w_clear = 1'b1;
          if (conv_done) begin
            w_capture   = 1'b1;
            w_state_nxt = STREAM;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_advance = w_hs;
          if (conv_done) begin
            w_drop = 1'b1;
          end else begin
            w_drop = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Tile buffer: loaded only on an accepted done, never reset.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_buf <= result_in;
    end
  end

  // Sticky overrun flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  // Stream outputs decoded from held state; zeroed while idle.
  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    m_row   = '0;
    m_col   = '0;
    m_last  = 1'b0;
    if (r_state == STREAM) begin
      m_valid = 1'b1;
      m_data  = r_buf[w_row][w_col];
      m_row   = w_row;
      m_col   = w_col;
      m_last  = w_last;
    end else begin
      m_valid = 1'b0;
      m_data  = '0;
      m_row   = '0;
      m_col   = '0;
      m_last  = 1'b0;
    end
  end

  assign busy    = m_valid;
  assign overrun = r_overrun;

endmodule

// File: doc/winograd_result_streamer.md
Name: winograd_result_streamer

Overview:
- Downstream stage of the 10x12 Winograd convolution engine.
- On the engine's done pulse, captures the full 8x10 parallel result array into a local tile buffer.
- Emits the tile as a valid/ready stream of 16-bit elements in row-major order, tagged with row/column indices and a last flag, for the writeback/display path.
- Decouples the engine from a slow consumer. A done that arrives while a tile is still streaming is dropped and flagged.

Parameters:
ROWS, 8, result tile rows
COLS, 10, result tile columns
DATA_WIDTH, 16, element width in bits

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
conv_done  input  1  single-cycle pulse from conv engine; result_in valid in that cycle
result_in  input  DATA_WIDTH x [0:ROWS-1][0:COLS-1]  parallel convolution result
m_valid  output  1  stream element valid
m_ready  input  1  consumer accepts element
m_data  output  DATA_WIDTH  current element
m_row  output  $clog2(ROWS)  row index of m_data
m_col  output  $clog2(COLS)  column index of m_data
m_last  output  1  high with element [ROWS-1][COLS-1]
busy  output  1  tile held and not fully streamed
overrun  output  1  sticky: conv_done dropped while busy
clr_overrun  input  1  clears overrun

Behaviour:
- Reset (rst high at a clk edge):
  - state IDLE; m_valid, m_data, m_row, m_col, m_last, busy and overrun all 0.
  - Reset mid-stream aborts the tile; outputs return to reset values the next cycle.
  - Tile buffer contents are not cleared (don't-care).
- States are IDLE and STREAM.
- IDLE:
  - m_valid=0, busy=0.
  - conv_done=1 latches all of result_in into the buffer and clears the index to (0,0). Next state is STREAM.
  - Latency: m_valid rises in the cycle after conv_done.
- STREAM:
  - m_valid=1, busy=1.
  - m_data = buf[m_row][m_col]; m_last = (m_row==ROWS-1 && m_col==COLS-1).
- Handshake is m_valid && m_ready.
  - On a handshake, m_col increments. At COLS-1 it wraps to 0 and m_row increments.
  - Without a handshake, m_data/m_row/m_col/m_last hold stable.
  - m_valid never drops before the handshake.
- Final handshake (m_last):
  - If conv_done is low: next state IDLE, m_valid=0 the next cycle.
  - If conv_done is high in the same cycle: capture the new tile, reset the index to (0,0) and stay in STREAM. m_valid stays 1 (no bubble); overrun is not set.
- conv_done in STREAM on any other cycle:
  - The tile is dropped; buffer and index are untouched; overrun is set to 1 next cycle.
- overrun clearing:
  - Cleared by clr_overrun. If clr_overrun and a drop occur in the same cycle, set wins.
- Input stability:
  - result_in changes after the capture cycle do not affect the stream.
- Throughput and widths:
  - With m_ready held high: one element per cycle, 80 cycles per tile.
  - m_data is a direct copy with no arithmetic or width change; when m_valid=0, m_data is driven 0.

Decomposition:
- Package winograd_pkg:
  - WG_TILE_ROWS=8, WG_TILE_COLS=10, WG_DATA_W=16.
  - State enum typedef wg_stream_state_t {IDLE, STREAM}.
  - Element typedef wg_elem_t (logic [WG_DATA_W-1:0]).
- Sub-module wg_tile_index_counter:
  - Row/column wrap counter with advance and clear inputs and a last output.
  - Reusable by the upstream image tile loader.
- Buffer register and output mux stay inline.

Test Plan:
- Basic stream: result_in[r][c]=r*10+c+1, conv_done pulse, m_ready=1 -> m_valid first high the cycle after the pulse; 80 beats carry data 1..80 with (row,col) row-major; m_last only on beat 80 (7,9); then m_valid=0, busy=0.
- Backpressure: same tile, m_ready toggles 1/0 each cycle -> data, row and col hold while m_ready=0; sequence still 1..80; no duplicated or skipped beats.
- Overrun: second conv_done (tile values 500+idx) at beat 40 -> overrun=1 next cycle; stream continues 41..80 unchanged; clr_overrun pulse -> overrun=0.
- Back-to-back: second conv_done (values 1000+idx) in the cycle of beat 80's handshake -> next cycle m_valid=1, data=1000, row/col=(0,0); overrun stays 0; stream of 1000..1079 follows.
- Reset mid-stream: rst high at beat 20 -> next cycle m_valid, busy, overrun and m_last are 0; a new conv_done restarts the stream from beat 1 with the new data.
- Capture isolation: result_in reassigned to all 16'hFFFF one cycle after conv_done -> streamed data is still 1..80.
